// File: rtl/acc_shift_merger.sv
// ============================================================================
// Module   : acc_shift_merger
// Brief    : XOR-deposits a 32-bit word into the cyclic accumulator RAM at an
//            arbitrary bit position using read-modify-write over one RAM port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_shift_merger #(
    parameter int WORD_WIDTH = 32,
    parameter int N_BITS     = 17669,
    parameter int NUM_WORDS  = 553,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] data_word,
    input  logic [ADDR_WIDTH-1:0] acc_start_idx,
    input  logic [4:0]            acc_shift_idx,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic                  mem_wr_en,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int                  LASTW_I  = N_BITS - WORD_WIDTH * (NUM_WORDS - 1);
    localparam logic [5:0]          LAST_W   = 6'(LASTW_I);
    localparam logic [5:0]          FULL_W   = 6'(WORD_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_LAT  = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t                  state_q;
    logic [WORD_WIDTH-1:0]   rem_q;
    logic [5:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   word_q;
    logic [4:0]              off_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    rd_q;
    logic                    wr_q;
    logic [WORD_WIDTH-1:0]   wdata_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;

    logic [5:0]              seg_width;
    logic [5:0]              avail;
    logic [5:0]              take;
    logic [WORD_WIDTH-1:0]   mask;
    logic [WORD_WIDTH-1:0]   contrib;
    logic [WORD_WIDTH-1:0]   rem_d;
    logic [5:0]              cnt_d;
    logic [ADDR_WIDTH-1:0]   word_d;
    logic                    req_invalid;

    // Segment geometry depends only on registered state, so it is stable
    // across RD/LAT/WR of the current segment.
    always_comb begin
        seg_width   = (word_q == LAST_IDX) ? LAST_W : FULL_W;
        avail       = seg_width - {1'b0, off_q};
        take        = (avail < cnt_q) ? avail : cnt_q;
        mask        = ~({WORD_WIDTH{1'b1}} << take);
        contrib     = (rem_q & mask) << off_q;
        rem_d       = rem_q >> take;
        cnt_d       = cnt_q - take;
        word_d      = (word_q == LAST_IDX) ? '0 : word_q + ADDR_WIDTH'(1);
        req_invalid = (acc_start_idx > LAST_IDX) ||
                      ((acc_start_idx == LAST_IDX) && ({1'b0, acc_shift_idx} >= LAST_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (req_invalid) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            rem_q   <= data_word;
                            cnt_q   <= FULL_W;
                            word_q  <= acc_start_idx;
                            off_q   <= acc_shift_idx;
                            addr_q  <= acc_start_idx;
                            rd_q    <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    state_q <= S_LAT;
                end
                S_LAT: begin
                    wdata_q <= mem_rdata ^ contrib;
                    wr_q    <= 1'b1;
                    state_q <= S_WR;
                end
                S_WR: begin
                    rem_q  <= rem_d;
                    cnt_q  <= cnt_d;
                    word_q <= word_d;
                    off_q  <= '0;
                    if (cnt_d != 6'd0) begin
                        addr_q  <= word_d;
                        rd_q    <= 1'b1;
                        state_q <= S_RD;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_rd_en = rd_q;
    assign mem_wr_en = wr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_acc_shift_merger.sv
// ============================================================================
// Module   : tb_acc_shift_merger
// Brief    : Scoreboard bench for acc_shift_merger with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acc_shift_merger;

    localparam int N_BITS    = 17669;
    localparam int NUM_WORDS = 553;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] data_word;
    logic [9:0]  acc_start_idx;
    logic [4:0]  acc_shift_idx;
    logic [9:0]  mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    acc_shift_merger dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .data_word     (data_word),
        .acc_start_idx (acc_start_idx),
        .acc_shift_idx (acc_shift_idx),
        .mem_addr      (mem_addr),
        .mem_rd_en     (mem_rd_en),
        .mem_rdata     (mem_rdata),
        .mem_wr_en     (mem_wr_en),
        .mem_wdata     (mem_wdata),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    logic [31:0] acc [0:NUM_WORDS-1];
    wr_t         exp_q [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          rd_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) mem_rdata <= acc[mem_addr];
        if (mem_wr_en) acc[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Write monitor: every RAM write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mem_rd_en) rd_cnt++;
        if (mem_rd_en || mem_wr_en) check("rdwr_excl", {63'd0, mem_rd_en & mem_wr_en}, 64'd0);
        if (mem_wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr", {54'd0, mem_addr}, 64'h3FF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {54'd0, mem_addr}, {54'd0, e.a});
                check("wr_data", {32'd0, mem_wdata}, {32'd0, e.d});
                if (mem_addr == 10'(NUM_WORDS - 1))
                    check("last_hi", {32'd0, mem_wdata & 32'hFFFF_FFE0}, 64'd0);
            end
        end
    end

    // Bit-level reference: bit j of data lands on polynomial bit (p+j) mod N.
    task automatic push_expected(input logic [31:0] d, input int idx, input int sh, output int nseg);
        logic [9:0]  wl [3];
        logic [31:0] dl [3];
        int n = 0;
        int p = idx * 32 + sh;
        for (int j = 0; j < 32; j++) begin
            int q = (p + j) % N_BITS;
            logic [9:0] wd = 10'(q / 32);
            if (n == 0 || wl[n-1] != wd) begin
                wl[n] = wd;
                dl[n] = acc[wd];
                n++;
            end
            dl[n-1][q % 32] = dl[n-1][q % 32] ^ d[j];
        end
        for (int k = 0; k < n; k++) exp_q.push_back('{a: wl[k], d: dl[k]});
        nseg = n;
    endtask

    task automatic run_op(input logic [31:0] d, input int idx, input int sh,
                          input bit exp_err, input bit repulse);
        int nseg = 0;
        int sc;
        bit got = 0;
        if (!exp_err) push_expected(d, idx, sh, nseg);
        rd_cnt = 0;
        @(negedge clk);
        data_word     = d;
        acc_start_idx = 10'(idx);
        acc_shift_idx = 5'(sh);
        start         = 1'b1;
        sc            = cyc;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (repulse && (i == 2 || i == 5)) begin
                start         = 1'b1;
                data_word     = ~d;
                acc_start_idx = 10'(idx + 1);
            end
            if (done) begin
                got = 1;
                break;
            end
        end
        start = 1'b0;
        check("done_seen", {63'd0, got}, 64'd1);
        check("latency", 64'(cyc - sc), 64'(3 * nseg + 1));
        check("err", {63'd0, err}, {63'd0, exp_err});
        if (exp_err) begin
            check("err_busy", {63'd0, busy}, 64'd0);
            check("err_rd", 64'(rd_cnt), 64'd0);
        end
        @(negedge clk);
        check("done_pulse", {63'd0, done}, 64'd0);
        check("pending", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        data_word = '0;
        acc_start_idx = '0;
        acc_shift_idx = '0;
        for (int i = 0; i < NUM_WORDS; i++) acc[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_rd", {63'd0, mem_rd_en}, 64'd0);
        check("rst_wr", {63'd0, mem_wr_en}, 64'd0);
        check("rst_addr", {54'd0, mem_addr}, 64'd0);
        rst = 1'b0;

        acc[5] = 32'h1234_5678;
        run_op(32'hDEAD_BEEF, 5, 0, 0, 0);
        check("t1_acc5", {32'd0, acc[5]}, {32'd0, 32'hCC99_E897});

        acc[5] = '0;
        run_op(32'hFFFF_FFFF, 5, 12, 0, 1);
        check("t2_acc5", {32'd0, acc[5]}, {32'd0, 32'hFFFF_F000});
        check("t2_acc6", {32'd0, acc[6]}, {32'd0, 32'h0000_0FFF});

        acc[551] = '0; acc[552] = '0; acc[0] = '0;
        run_op(32'hFFFF_FFFF, 551, 28, 0, 0);
        check("t3_acc551", {32'd0, acc[551]}, {32'd0, 32'hF000_0000});
        check("t3_acc552", {32'd0, acc[552]}, {32'd0, 32'h0000_001F});
        check("t3_acc0", {32'd0, acc[0]}, {32'd0, 32'h007F_FFFF});

        acc[552] = 32'h1; acc[0] = '0;
        run_op(32'hFFFF_FFFF, 552, 3, 0, 0);
        check("t4_acc552", {32'd0, acc[552]}, {32'd0, 32'h0000_0019});
        check("t4_acc0", {32'd0, acc[0]}, {32'd0, 32'h3FFF_FFFF});

        run_op(32'hA5A5_A5A5, 552, 5, 1, 0);
        run_op(32'hA5A5_A5A5, 600, 0, 1, 0);
        run_op(32'h0000_0001, 552, 4, 0, 0);

        // Reset during LAT: the pending write must be dropped.
        @(negedge clk);
        data_word = 32'hFFFF_FFFF; acc_start_idx = 10'd7; acc_shift_idx = 5'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_busy", {63'd0, busy}, 64'd0);
        check("mid_rd", {63'd0, mem_rd_en}, 64'd0);
        check("mid_wr", {63'd0, mem_wr_en}, 64'd0);
        check("mid_done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_acc7", {32'd0, acc[7]}, 64'd0);

        acc[5] = 32'h1234_5678;
        run_op(32'hDEAD_BEEF, 5, 0, 0, 0);
        check("t6_acc5", {32'd0, acc[5]}, {32'd0, 32'hCC99_E897});

        for (int i = 0; i < NUM_WORDS - 1; i++) acc[i] = $urandom;
        acc[NUM_WORDS-1] = $urandom & 32'h1F;
        for (int t = 0; t < 12; t++) begin
            int idx = $urandom_range(0, NUM_WORDS - 1);
            int sh  = (idx == NUM_WORDS - 1) ? $urandom_range(0, 4) : $urandom_range(0, 31);
            run_op($urandom, idx, sh, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/acc_shift_merger.md
Name: acc_shift_merger

Overview:
Write-side counterpart of the initial shift processor. It takes one 32-bit product word and XOR-deposits it into the cyclic accumulator RAM (x^N - 1, N=17669) at an arbitrary bit position given by (acc_start_idx, acc_shift_idx). The deposit spans 1 to 3 accumulator words, including the 5-bit last word and the wrap to word 0, and is done by read-modify-write over a single synchronous RAM port. It sits between the shift datapath and the accumulator RAM in the sparse polynomial multiplier.

Parameters:
WORD_WIDTH, 32, accumulator word width
N_BITS, 17669, polynomial length in bits
NUM_WORDS, 553, accumulator words (ceil(N_BITS/32))
ADDR_WIDTH, 10, RAM address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; accepted only when busy=0
data_word  in  WORD_WIDTH  word to deposit; bit j goes to polynomial bit (p+j) mod N_BITS
acc_start_idx  in  ADDR_WIDTH  start word index
acc_shift_idx  in  5  bit offset in start word; p = acc_start_idx*32 + acc_shift_idx
mem_addr  out  ADDR_WIDTH  RAM address
mem_rd_en  out  1  RAM read strobe; data on mem_rdata next cycle
mem_rdata  in  WORD_WIDTH  RAM read data
mem_wr_en  out  1  RAM write strobe
mem_wdata  out  WORD_WIDTH  RAM write data
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
err  out  1  valid with done; 1 = position rejected, no RAM access

Behaviour:
- Reset (synchronous, rst=1): every output is 0. FSM goes to IDLE. Internal registers are cleared.
- Reset mid-operation: all strobes are 0 from the next edge. The pending write is dropped and done is not pulsed.
- Word widths: words 0..NUM_WORDS-2 hold 32 valid bits. The last word holds LASTW = N_BITS-32*(NUM_WORDS-1) = 5 valid bits. Its bits 5..31 are never written nonzero.
- Validation at start: the request is invalid if acc_start_idx > NUM_WORDS-1, or if acc_start_idx = NUM_WORDS-1 and acc_shift_idx >= LASTW.
  - Invalid request: the cycle after start gives done=1, err=1, busy=0, with no rd/wr.
- Latch at start: rem <= data_word, cnt <= 32, w <= acc_start_idx, o <= acc_shift_idx.
- Segment rule, applied per segment:
  - avail = width(w) - o
  - take = min(avail, cnt)
  - contrib = (rem & ((1<<take)-1)) << o
  - then rem >>= take, cnt -= take
  - w <= (w = NUM_WORDS-1) ? 0 : w+1, and o <= 0
  - Finish when cnt = 0. The maximum is 3 segments.
- FSM states: IDLE, RD, LAT, WR, FIN, all with registered outputs.
  - IDLE, valid start: go to RD, busy=1.
  - RD: mem_rd_en=1, mem_addr=w.
  - LAT: RAM access in flight; mem_rdata is captured at the end of LAT.
  - WR: mem_wr_en=1, mem_addr=w, mem_wdata = captured rdata XOR contrib. Go to RD if cnt>0 after this segment, otherwise FIN.
  - FIN: done=1, err=0. Go to IDLE; busy falls with done.
- Timing: each segment takes 3 cycles. For S segments, done is asserted 3S+1 cycles after the start cycle.
- start while busy=1 is ignored and does not affect the current operation.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- mem_addr is held when idle.

Test Plan:
1. acc[5]=0x12345678, data=0xDEADBEEF, idx=5, shift=0 -> one write to addr 5 with wdata 0xCC99E897; done 4 cycles after start, err=0.
2. acc zeroed, data=0xFFFFFFFF, idx=5, shift=12 -> writes acc[5]=0xFFFFF000 then acc[6]=0x00000FFF; done at +7.
3. acc zeroed, data=0xFFFFFFFF, idx=551, shift=28 -> writes in order acc[551]=0xF0000000, acc[552]=0x0000001F, acc[0]=0x007FFFFF; done at +10.
4. acc[552]=0x00000001, data=0xFFFFFFFF, idx=552, shift=3 -> acc[552]=0x00000019, acc[0]=0x3FFFFFFF; acc[552] bits 5..31 stay 0.
5. idx=552, shift=5 and separately idx=600 -> done=1, err=1 one cycle after start; mem_rd_en and mem_wr_en stay 0.
6. start re-pulsed during case 2 is ignored (identical writes). rst=1 asserted in LAT -> no write issued, busy=0 and strobes 0 after the edge; a following case 1 completes correctly.
